// File: rtl/seg_scan_pkg.sv
// Shared types, glyph table and width helper for the 7-segment scan driver.
package seg_scan_pkg;

   typedef logic [7:0] seg_t;

   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;

   // bit0=a .. bit6=g, dp clear
   localparam seg_t HEX_GLYPH [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Writer/display bundle of seg_scan_mux; wr_blink exists only with SEG_SCAN_BLINK_EN.
interface seg_scan_mux_if
   import seg_scan_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int NUM_GRP     = 8,
   parameter int DIG_PER_GRP = 8
);
   localparam int D  = NUM_GRP * DIG_PER_GRP;
   localparam int PW = cw(D / 4);

   logic                         clr;
   logic [NUM_CH-1:0]            wr_en;
   logic [NUM_CH-1:0]            wr_raw;
   logic [NUM_CH-1:0][15:0]      wr_dat;
   logic [NUM_CH-1:0][PW-1:0]    wr_pos;
`ifdef SEG_SCAN_BLINK_EN
   logic [NUM_CH-1:0]            wr_blink;
`endif
   seg_t [DIG_PER_GRP-1:0]       seg;
   logic [NUM_GRP-1:0]           grp_sel;
   logic                         frame_start;

   modport master (
      output clr, wr_en, wr_raw, wr_dat, wr_pos,
`ifdef SEG_SCAN_BLINK_EN
      output wr_blink,
`endif
      input  seg, grp_sel, frame_start
   );

   modport slave (
      input  clr, wr_en, wr_raw, wr_dat, wr_pos,
`ifdef SEG_SCAN_BLINK_EN
      input  wr_blink,
`endif
      output seg, grp_sel, frame_start
   );

endinterface

// File: rtl/seg_hex_decoder.sv
// One hex nibble to its 7-segment glyph, dp off.
module seg_hex_decoder
   import seg_scan_pkg::*;
(
   input  logic [3:0] nib,
   output seg_t       seg
);
   assign seg = HEX_GLYPH[nib];
endmodule

// File: rtl/seg_scan_mux.sv
// Multi-writer digit buffer with blank/drive group scanning.
// Optional per-digit blinking is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int NUM_GRP     = 8,
   parameter int DIG_PER_GRP = 8,
   parameter int SCAN_DIV    = 1,
   parameter int BLANK_TICKS = 1,
   parameter int DRIVE_TICKS = 1
`ifdef SEG_SCAN_BLINK_EN
   , parameter int BLINK_FRAMES = 32
`endif
) (
   input logic           clk,
   input logic           reset,
   seg_scan_mux_if.slave bus
);
   localparam int D       = NUM_GRP * DIG_PER_GRP;
   localparam int NWORD   = D / 4;
   localparam int PW      = cw(NWORD);
   localparam int GW      = cw(NUM_GRP);
   localparam int PRW     = cw(SCAN_DIV);
   localparam int TW      = cw((BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS);
   localparam int BT_LAST = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;

   seg_t              hex [NUM_CH][4];
   logic [NUM_CH-1:0] pos_ok;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      for (genvar i = 0; i < 4; i++) begin : g_nib
         seg_hex_decoder u_dec (.nib(bus.wr_dat[c][4*i +: 4]), .seg(hex[c][i]));
      end
      if ((1 << PW) == NWORD) begin : g_full
         assign pos_ok[c] = 1'b1;
      end else begin : g_lim
         assign pos_ok[c] = (bus.wr_pos[c] < PW'(NWORD));
      end
   end

   // Digit buffer; channels applied high to low so the lowest index lands last.
   seg_t dbuf_q [NUM_GRP][DIG_PER_GRP];
   seg_t dbuf_nx[NUM_GRP][DIG_PER_GRP];
`ifdef SEG_SCAN_BLINK_EN
   logic blk_q  [NUM_GRP][DIG_PER_GRP];
   logic blk_nx [NUM_GRP][DIG_PER_GRP];
`endif

   always_comb begin
      dbuf_nx = dbuf_q;
`ifdef SEG_SCAN_BLINK_EN
      blk_nx = blk_q;
`endif
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         for (int g = 0; g < NUM_GRP; g++) begin
            for (int k = 0; k < DIG_PER_GRP; k++) begin
               if (bus.wr_en[c] && pos_ok[c] &&
                   bus.wr_pos[c] == PW'((g * DIG_PER_GRP + k) / 4)) begin
                  if (!bus.wr_raw[c]) begin
                     dbuf_nx[g][k] = hex[c][(g * DIG_PER_GRP + k) % 4];
`ifdef SEG_SCAN_BLINK_EN
                     blk_nx[g][k] = bus.wr_blink[c];
`endif
                  end else if ((g * DIG_PER_GRP + k) % 4 < 2) begin
                     dbuf_nx[g][k] = ((g * DIG_PER_GRP + k) % 4 == 0) ?
                                     bus.wr_dat[c][7:0] : bus.wr_dat[c][15:8];
`ifdef SEG_SCAN_BLINK_EN
                     blk_nx[g][k] = bus.wr_blink[c];
`endif
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clr) begin
         dbuf_q <= '{default: '0};
`ifdef SEG_SCAN_BLINK_EN
         blk_q  <= '{default: '0};
`endif
      end else begin
         dbuf_q <= dbuf_nx;
`ifdef SEG_SCAN_BLINK_EN
         blk_q  <= blk_nx;
`endif
      end
   end

   // Scan timing; all state changes happen on ticks, so a zero-length blank
   // after reset still waits for the first tick and every drive is full length.
   scan_state_t      st_q, st_nx;
   logic [GW-1:0]    g_q, g_nx;
   logic [TW-1:0]    t_q, t_nx;
   logic [PRW-1:0]   pre_q;
   logic             tick, first_drv;

   assign tick      = (pre_q == PRW'(SCAN_DIV - 1));
   assign first_drv = (st_q == DRIVE) && (g_q == '0) && (t_q == '0) && (pre_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
         st_q  <= BLANK;
         g_q   <= '0;
         t_q   <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + 1'b1;
         st_q  <= st_nx;
         g_q   <= g_nx;
         t_q   <= t_nx;
      end
   end

   always_comb begin
      st_nx = st_q;
      g_nx  = g_q;
      t_nx  = t_q;
      if (tick) begin
         case (st_q)
            BLANK: begin
               if (BLANK_TICKS == 0 || t_q == TW'(BT_LAST)) begin
                  st_nx = DRIVE;
                  t_nx  = '0;
               end else begin
                  t_nx = t_q + 1'b1;
               end
            end
            DRIVE: begin
               if (t_q == TW'(DRIVE_TICKS - 1)) begin
                  t_nx  = '0;
                  g_nx  = (g_q == GW'(NUM_GRP - 1)) ? '0 : g_q + 1'b1;
                  st_nx = (BLANK_TICKS == 0) ? DRIVE : BLANK;
               end else begin
                  t_nx = t_q + 1'b1;
               end
            end
            default: st_nx = BLANK;
         endcase
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   localparam int FW = cw(BLINK_FRAMES + 1);
   logic [FW-1:0] fcnt_q;
   logic          ph_q, tog, ph_on;

   // Phase flips on the frame start that follows BLINK_FRAMES full frames.
   assign tog   = first_drv && (fcnt_q == FW'(BLINK_FRAMES));
   assign ph_on = ph_q ^ tog;

   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q <= '0;
         ph_q   <= 1'b1;
      end else if (first_drv) begin
         fcnt_q <= tog ? FW'(1) : fcnt_q + 1'b1;
         ph_q   <= ph_on;
      end
   end
`endif

   seg_t [DIG_PER_GRP-1:0] seg_nx, seg_q;
   logic [NUM_GRP-1:0]     sel_nx, sel_q;
   logic                   fs_q;

   always_comb begin
      sel_nx = '0;
      seg_nx = '0;
      if (st_q == DRIVE) begin
         sel_nx = NUM_GRP'(1) << g_q;
         for (int k = 0; k < DIG_PER_GRP; k++) begin
            seg_nx[k] = dbuf_q[g_q][k];
`ifdef SEG_SCAN_BLINK_EN
            if (blk_q[g_q][k] && !ph_on) seg_nx[k] = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q <= '0;
         sel_q <= '0;
         fs_q  <= 1'b0;
      end else begin
         seg_q <= seg_nx;
         sel_q <= sel_nx;
         fs_q  <= first_drv;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.grp_sel     = sel_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Two seg_scan_mux configurations driven with shared random writes and
// compared every cycle against a timing-formula reference model.
module tb_seg_scan_mux;
   localparam int NC = 8, DPG = 8, NG0 = 8, NG1 = 6, BF0 = 2, BF1 = 3;
`ifdef SEG_SCAN_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic                   clr;
   logic [NC-1:0]          wr_en, wr_raw, wr_blink;
   logic [NC-1:0][15:0]    wr_dat;
   logic [NC-1:0][3:0]     wr_pos;

   seg_scan_mux_if #(.NUM_CH(NC), .NUM_GRP(NG0), .DIG_PER_GRP(DPG)) bus0 ();
   seg_scan_mux_if #(.NUM_CH(NC), .NUM_GRP(NG1), .DIG_PER_GRP(DPG)) bus1 ();

   assign bus0.clr = clr;  assign bus1.clr = clr;
   assign bus0.wr_en = wr_en;  assign bus1.wr_en = wr_en;
   assign bus0.wr_raw = wr_raw;  assign bus1.wr_raw = wr_raw;
   assign bus0.wr_dat = wr_dat;  assign bus1.wr_dat = wr_dat;
   assign bus0.wr_pos = wr_pos;  assign bus1.wr_pos = wr_pos;
`ifdef SEG_SCAN_BLINK_EN
   assign bus0.wr_blink = wr_blink;  assign bus1.wr_blink = wr_blink;
`endif

   seg_scan_mux #(.NUM_CH(NC), .NUM_GRP(NG0), .DIG_PER_GRP(DPG),
                  .SCAN_DIV(1), .BLANK_TICKS(1), .DRIVE_TICKS(1)
`ifdef SEG_SCAN_BLINK_EN
                  , .BLINK_FRAMES(BF0)
`endif
   ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

   seg_scan_mux #(.NUM_CH(NC), .NUM_GRP(NG1), .DIG_PER_GRP(DPG),
                  .SCAN_DIV(3), .BLANK_TICKS(0), .DRIVE_TICKS(2)
`ifdef SEG_SCAN_BLINK_EN
                  , .BLINK_FRAMES(BF1)
`endif
   ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   int n_vec = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int cfg_ng[2] = '{NG0, NG1};
   int cfg_sd[2] = '{1, 3};
   int cfg_bt[2] = '{1, 0};
   int cfg_dt[2] = '{1, 2};
   int cfg_bf[2] = '{BF0, BF1};
   logic [7:0] glyph[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   logic [7:0]  mbuf[2][64];
   bit          mblk[2][64];
   int          mc[2], nf[2];
   logic [63:0] exp_seg[2];
   logic [7:0]  exp_sel[2];
   logic        exp_fs[2];

   // Group shown in cycle c after reset (-1 = blanking), from tick arithmetic.
   function automatic int grp_at(input int c, input int u);
      int j, p;
      if (c < 0) return -1;
      j = c / cfg_sd[u];
      if (cfg_bt[u] > 0) begin
         p = cfg_bt[u] + cfg_dt[u];
         if (j % p < cfg_bt[u]) return -1;
         return (j / p) % cfg_ng[u];
      end
      if (j == 0) return -1;
      return ((j - 1) / cfg_dt[u]) % cfg_ng[u];
   endfunction

   task automatic model_step(input int u);
      int g, gp, d, n;
      bit on, fs;
      bit claimed[64];
      logic [7:0] b;
      if (reset) begin
         exp_seg[u] = '0; exp_sel[u] = '0; exp_fs[u] = 1'b0;
         mc[u] = 0; nf[u] = 0;
         for (int i = 0; i < 64; i++) begin mbuf[u][i] = '0; mblk[u][i] = 1'b0; end
         return;
      end
      g  = grp_at(mc[u], u);
      gp = grp_at(mc[u] - 1, u);
      fs = (g == 0) && (gp != 0);
      if (fs) nf[u]++;
      on = (nf[u] == 0) || (((nf[u] - 1) / cfg_bf[u]) % 2 == 0);
      exp_fs[u]  = fs;
      exp_sel[u] = (g < 0) ? 8'h00 : (8'h01 << g);
      exp_seg[u] = '0;
      if (g >= 0)
         for (int k = 0; k < DPG; k++) begin
            d = g * DPG + k;
            b = (BLINK_ON && mblk[u][d] && !on) ? 8'h00 : mbuf[u][d];
            exp_seg[u][8*k +: 8] = b;
         end
      mc[u]++;
      if (clr) begin
         for (int i = 0; i < 64; i++) begin mbuf[u][i] = '0; mblk[u][i] = 1'b0; end
         return;
      end
      for (int i = 0; i < 64; i++) claimed[i] = 1'b0;
      for (int c = 0; c < NC; c++) begin
         if (!wr_en[c] || int'(wr_pos[c]) >= cfg_ng[u] * DPG / 4) continue;
         n = wr_raw[c] ? 2 : 4;
         for (int i = 0; i < n; i++) begin
            d = int'(wr_pos[c]) * 4 + i;
            if (claimed[d]) continue;
            claimed[d] = 1'b1;
            mbuf[u][d] = wr_raw[c] ? wr_dat[c][8*i +: 8] : glyph[wr_dat[c][4*i +: 4]];
            mblk[u][d] = BLINK_ON && wr_blink[c];
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step(0);
         model_step(1);
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("sel0", 64'(bus0.grp_sel), 64'(exp_sel[0]));
         chk("fs0",  64'(bus0.frame_start), 64'(exp_fs[0]));
         chk("seg0", bus0.seg, exp_seg[0]);
         chk("sel1", 64'(bus1.grp_sel), 64'(exp_sel[1]));
         chk("fs1",  64'(bus1.frame_start), 64'(exp_fs[1]));
         chk("seg1", bus1.seg, exp_seg[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      clr = 1'b0; wr_en = '0; wr_raw = '0; wr_blink = '0; wr_dat = '0; wr_pos = '0;
   endtask

   task automatic wait_sel(input logic [7:0] sel);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus0.grp_sel == sel) found = 1'b1;
      end
      if (!found) chk("wait_sel", 64'(bus0.grp_sel), 64'(sel));
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      wr_en[0] = 1'b1; wr_pos[0] = 4'd0; wr_dat[0] = 16'hF8A1; wr_blink[0] = 1'b1;
      @(negedge clk); idle();
      wait_sel(8'h01);
      chk("hex_glyphs", 64'(bus0.seg[3:0]), 64'h717F7706);

      wr_en[0] = 1'b1; wr_pos[0] = 4'd3; wr_dat[0] = 16'h8A00;
      @(negedge clk); idle();
      wr_en[2] = 1'b1; wr_raw[2] = 1'b1; wr_pos[2] = 4'd3; wr_dat[2] = 16'hC0FF;
      @(negedge clk); idle();
      wait_sel(8'h02);
      chk("raw_bytes", 64'(bus0.seg[7:4]), 64'h7F77C0FF);

      wr_en[1] = 1'b1; wr_pos[1] = 4'd2; wr_dat[1] = 16'h8A10;
      wr_en[5] = 1'b1; wr_pos[5] = 4'd2; wr_dat[5] = 16'hFFFF;
      @(negedge clk); idle();
      wait_sel(8'h02);
      chk("ch_prio", 64'(bus0.seg[3:0]), 64'h7F77063F);

      wr_en[4] = 1'b1; wr_pos[4] = 4'd13; wr_dat[4] = 16'h1234;
      @(negedge clk); idle();
      clr = 1'b1; wr_en[3] = 1'b1; wr_pos[3] = 4'd0; wr_dat[3] = 16'h8888;
      @(negedge clk); idle();
      wait_sel(8'h01);
      chk("clr_seg", bus0.seg, 64'h0);

      wr_en[0] = 1'b1; wr_pos[0] = 4'd4; wr_dat[0] = 16'hABCD;
      @(negedge clk); idle();
      wait_sel(8'h04);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_sel", 64'(bus0.grp_sel), 64'h0);
      chk("rst_seg", bus0.seg, 64'h0);

      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NC; c++) begin
            wr_en[c]    = ($urandom_range(0, 5) == 0);
            wr_raw[c]   = 1'($urandom_range(0, 1));
            wr_blink[c] = 1'($urandom_range(0, 1));
            wr_dat[c]   = 16'($urandom);
            wr_pos[c]   = 4'($urandom);
         end
         clr   = ($urandom_range(0, 199) == 0);
         reset = (n == 777);
         @(negedge clk);
      end
      idle();
      reset = 1'b0;
      repeat (100) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
